// File: rtl/serial_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pattern_detector
//  Description : Serial bit-stream pattern detector. Keeps a WIDTH-bit shift
//                history of accepted bits and detects PATTERN, with optional
//                overlapping matches. Emits a one-cycle registered detect
//                pulse per match and keeps a saturating match count.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_detector #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8,
    parameter bit               OVERLAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_din,
    input  logic             i_en,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_shift,
    output logic             o_filled,
    output logic             o_detect,
    output logic [CNT_W-1:0] o_count
);

    // Fill counter must represent 0..WIDTH inclusive.
    localparam int                c_FILL_W   = $clog2(WIDTH + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(WIDTH);
    localparam logic [c_FILL_W-1:0] c_FILL_ARM = c_FILL_W'(WIDTH - 1);
    localparam logic [c_FILL_W-1:0] c_FILL_ONE = c_FILL_W'(1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_FILL_W-1:0] r_fill;
    logic [c_FILL_W-1:0] w_fill_nxt;
    logic [c_FILL_W-1:0] w_fill_inc;
    logic [WIDTH-1:0]    r_shift;
    logic [WIDTH-1:0]    w_shift_nxt;
    logic [WIDTH-1:0]    w_shift_cat;
    logic                r_detect;
    logic                w_detect_nxt;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                w_hit;

    // History with the incoming bit appended; the match is judged on this.
    assign w_shift_cat = {r_shift[WIDTH-2:0], i_din};
    assign w_fill_inc  = r_fill + c_FILL_ONE;
    // The fill gate stops matches against leftover zeros after reset/clear.
    assign w_hit       = (w_shift_cat == PATTERN) && (r_fill >= c_FILL_ARM);

    // Next-state logic: clear beats enable, enable beats hold.
    always_comb begin
        w_state_nxt  = r_state;
        w_fill_nxt   = r_fill;
        w_shift_nxt  = r_shift;
        w_detect_nxt = 1'b0;
        w_count_nxt  = r_count;
        if (i_clear) begin
            w_state_nxt = S_EMPTY;
            w_fill_nxt  = '0;
            w_shift_nxt = '0;
            w_count_nxt = '0;
        end else if (i_en) begin
            w_shift_nxt = w_shift_cat;
            case (r_state)
                S_EMPTY: begin
                    w_fill_nxt  = c_FILL_ONE;
                    w_state_nxt = (WIDTH == 1) ? S_FULL : S_FILL;
                end
                S_FILL: begin
                    w_fill_nxt = w_fill_inc;
                    if (w_fill_inc == c_FILL_MAX) begin
                        w_state_nxt = S_FULL;
                    end
                end
                S_FULL: begin
                    w_fill_nxt  = c_FILL_MAX;
                    w_state_nxt = S_FULL;
                end
                default: begin
                    w_fill_nxt  = '0;
                    w_state_nxt = S_EMPTY;
                end
            endcase
            if (w_hit) begin
                w_detect_nxt = 1'b1;
                if (r_count != {CNT_W{1'b1}}) begin
                    w_count_nxt = r_count + 1'b1;
                end
                // Non-overlapping mode: the history must refill completely.
                if (!OVERLAP) begin
                    w_fill_nxt  = '0;
                    w_state_nxt = S_EMPTY;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_EMPTY;
            r_fill   <= '0;
            r_shift  <= '0;
            r_detect <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_fill   <= w_fill_nxt;
            r_shift  <= w_shift_nxt;
            r_detect <= w_detect_nxt;
            r_count  <= w_count_nxt;
        end
    end

    assign o_shift  = r_shift;
    assign o_filled = (r_state == S_FULL);
    assign o_detect = r_detect;
    assign o_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_pattern_detector
//  Description : Self-checking bench. Four detector configurations share one
//                directed stimulus stream and are compared every cycle against
//                a behavioural model, plus literal spot checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_detector;

    logic clk = 1'b0;
    logic rst_n;
    logic din;
    logic en;
    logic clr;

    // Instance set: 0 = 1011/overlap, 1 = 1011/no overlap,
    //               2 = 0000/overlap, 3 = 1011/overlap with 2-bit count
    logic [3:0] sh0, sh1, sh2, sh3;
    logic       fl0, fl1, fl2, fl3;
    logic       dt0, dt1, dt2, dt3;
    logic [7:0] ct0, ct1, ct2;
    logic [1:0] ct3;

    int d_shift[4];
    int d_filled[4];
    int d_det[4];
    int d_cnt[4];

    int p_pat[4] = '{11, 11, 0, 11};
    int p_ov[4]  = '{1, 0, 1, 1};
    int p_max[4] = '{255, 255, 255, 3};

    int m_shift[4] = '{0, 0, 0, 0};
    int m_since[4] = '{0, 0, 0, 0};
    int m_det[4]   = '{0, 0, 0, 0};
    int m_cnt[4]   = '{0, 0, 0, 0};

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    serial_pattern_detector #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(8), .OVERLAP(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_din(din), .i_en(en), .i_clear(clr),
        .o_shift(sh0), .o_filled(fl0), .o_detect(dt0), .o_count(ct0));
    serial_pattern_detector #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(8), .OVERLAP(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_din(din), .i_en(en), .i_clear(clr),
        .o_shift(sh1), .o_filled(fl1), .o_detect(dt1), .o_count(ct1));
    serial_pattern_detector #(.WIDTH(4), .PATTERN(4'b0000), .CNT_W(8), .OVERLAP(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_din(din), .i_en(en), .i_clear(clr),
        .o_shift(sh2), .o_filled(fl2), .o_detect(dt2), .o_count(ct2));
    serial_pattern_detector #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(2), .OVERLAP(1'b1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i_din(din), .i_en(en), .i_clear(clr),
        .o_shift(sh3), .o_filled(fl3), .o_detect(dt3), .o_count(ct3));

    always_comb begin
        d_shift[0] = int'(sh0); d_shift[1] = int'(sh1); d_shift[2] = int'(sh2); d_shift[3] = int'(sh3);
        d_filled[0] = int'(fl0); d_filled[1] = int'(fl1); d_filled[2] = int'(fl2); d_filled[3] = int'(fl3);
        d_det[0] = int'(dt0); d_det[1] = int'(dt1); d_det[2] = int'(dt2); d_det[3] = int'(dt3);
        d_cnt[0] = int'(ct0); d_cnt[1] = int'(ct1); d_cnt[2] = int'(ct2); d_cnt[3] = int'(ct3);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: history of accepted bits, bits-since-refill, match pulse, count.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (clr) begin
                    m_shift[k] = 0; m_since[k] = 0; m_det[k] = 0; m_cnt[k] = 0;
                end else if (en) begin
                    int h;
                    bit hit;
                    h   = ((m_shift[k] << 1) | int'(din)) & 15;
                    hit = (h == p_pat[k]) && (m_since[k] >= 3);
                    m_shift[k] = h;
                    if (hit && p_ov[k] == 0) m_since[k] = 0;
                    else m_since[k] = (m_since[k] + 1 > 4) ? 4 : m_since[k] + 1;
                    m_det[k] = hit ? 1 : 0;
                    if (hit && m_cnt[k] < p_max[k]) m_cnt[k] = m_cnt[k] + 1;
                end else begin
                    m_det[k] = 0;
                end
            end
        end
    end

    always @(negedge rst_n) begin
        for (int k = 0; k < 4; k++) begin
            m_shift[k] = 0; m_since[k] = 0; m_det[k] = 0; m_cnt[k] = 0;
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cyc shift[%0d]", k), d_shift[k], m_shift[k]);
            chk($sformatf("cyc filled[%0d]", k), d_filled[k], (m_since[k] == 4) ? 1 : 0);
            chk($sformatf("cyc detect[%0d]", k), d_det[k], m_det[k]);
            chk($sformatf("cyc count[%0d]", k), d_cnt[k], m_cnt[k]);
        end
    end

    task automatic step(input logic c, input logic e, input logic d);
        @(negedge clk);
        #1;
        clr = c; en = e; din = d;
    endtask

    task automatic feed(input logic d);
        step(1'b0, 1'b1, d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; en = 1'b0; din = 1'b0;
        #12;
        chk("reset shift", d_shift[0], 0);
        chk("reset count", d_cnt[0], 0);
        chk("reset filled", d_filled[0], 0);
        chk("reset detect", d_det[0], 0);
        @(negedge clk); #2; rst_n = 1'b1;

        // 1: basic match 1,0,1,1
        feed(1); feed(0); feed(1); feed(1);
        chk("t1 shift", d_shift[0], 11);
        chk("t1 detect", d_det[0], 1);
        chk("t1 count", d_cnt[0], 1);
        step(0, 0, 0); @(posedge clk); #1;
        chk("t1 detect one cycle", d_det[0], 0);

        // 2: overlap vs. non-overlap on 1,0,1,1,0,1,1
        step(1, 0, 0); @(posedge clk); #1;
        feed(1); feed(0); feed(1); feed(1); feed(0); feed(1); feed(1);
        chk("t2 ovl detect", d_det[0], 1);
        chk("t2 ovl count", d_cnt[0], 2);
        chk("t2 novl detect", d_det[1], 0);
        chk("t2 novl count", d_cnt[1], 1);

        // 3: enable gap holds history
        step(1, 0, 0); @(posedge clk); #1;
        feed(1); feed(0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, logic'(i % 2 == 0)); @(posedge clk); #1;
            chk("t3 shift hold", d_shift[0], 2);
        end
        feed(1);
        chk("t3 no early detect", d_det[0], 0);
        feed(1);
        chk("t3 detect", d_det[0], 1);
        chk("t3 count", d_cnt[0], 1);

        // 4: all-zero pattern gated by fill
        step(1, 0, 0); @(posedge clk); #1;
        feed(0); feed(0); feed(0);
        chk("t4 detect early", d_det[2], 0);
        chk("t4 filled early", d_filled[2], 0);
        feed(0);
        chk("t4 filled", d_filled[2], 1);
        chk("t4 detect", d_det[2], 1);

        // 5: saturating 2-bit counter over 5 matches
        step(1, 0, 0); @(posedge clk); #1;
        feed(1); feed(0); feed(1); feed(1);
        chk("t5 count 1", d_cnt[3], 1);
        for (int i = 0; i < 4; i++) begin
            feed(0); feed(1); feed(1);
            chk("t5 detect", d_det[3], 1);
            chk("t5 count sat", d_cnt[3], (i + 2 > 3) ? 3 : i + 2);
        end

        // 6: asynchronous reset mid-stream, then clear beats enable
        feed(1); feed(0); feed(1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t6 async shift", d_shift[0], 0);
        chk("t6 async count", d_cnt[3], 0);
        chk("t6 async filled", d_filled[0], 0);
        chk("t6 async detect", d_det[0], 0);
        @(negedge clk); #2; rst_n = 1'b1;
        step(1, 1, 1); @(posedge clk); #1;
        chk("t6 clear shift", d_shift[0], 0);
        chk("t6 clear count", d_cnt[0], 0);
        step(0, 0, 0);
        feed(1); feed(0); feed(1); feed(1);
        chk("t6 detect", d_det[0], 1);
        chk("t6 count", d_cnt[0], 1);

        step(0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
